// File: rtl/apb_capture_timer_if.sv
// APB3 bus bundle between the AHB-to-APB bridge mux slot and the capture timer.
interface apb_capture_timer_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_capture_timer.sv
// APB3 down-counter with auto-reload, one-shot mode and a resynchronised input-capture channel.
// Raises a registered level interrupt on timeout or capture.
module apb_capture_timer #(
  parameter int CNT_W       = 32,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_capture_timer_if.slave   apb,
  input  logic                 CAPIN,
  output logic                 TIMERINT
);

  localparam logic [ADDR_W-3:0] OFF_CTRL    = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] OFF_VALUE   = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] OFF_RELOAD  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] OFF_CAPTURE = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] OFF_INTSTAT = (ADDR_W-2)'(4);

  logic [3:0]             ctrl_r;
  logic [CNT_W-1:0]       value_r;
  logic [CNT_W-1:0]       reload_r;
  logic [CNT_W-1:0]       capture_r;
  logic [1:0]             intstat_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;
  logic                   edge_r;
  logic                   timerint_r;

  logic [ADDR_W-3:0]      word_s;
  logic                   wr_s;
  logic                   rd_s;
  logic [31:0]            rdata_s;
  logic                   slverr_s;
  logic                   timeout_s;
  logic                   capt_set_s;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [CNT_W-1:0]       value_nxt_s;
  logic [3:0]             ctrl_hw_s;
  logic [3:0]             ctrl_nxt_s;
  logic [1:0]             w1c_s;
  logic [1:0]             intstat_nxt_s;
  logic                   unused_s;

  // APB access decode and combinational read mux.
  always_comb begin
    word_s   = apb.PADDR[ADDR_W-1:2];
    wr_s     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    rd_s     = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    slverr_s = wr_s & (word_s == OFF_CAPTURE);
    rdata_s  = 32'h0000_0000;
    if (rd_s) begin
      case (word_s)
        OFF_CTRL:    rdata_s = {28'h000_0000, ctrl_r};
        OFF_VALUE:   rdata_s = 32'(value_r);
        OFF_RELOAD:  rdata_s = 32'(reload_r);
        OFF_CAPTURE: rdata_s = 32'(capture_r);
        OFF_INTSTAT: rdata_s = {30'h0000_0000, intstat_r};
        default:     rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Counter next state; an APB write to VALUE or CTRL overrides hardware updates.
  always_comb begin
    timeout_s = 1'b0;
    cnt_nxt_s = value_r;
    ctrl_hw_s = ctrl_r;
    if (ctrl_r[0]) begin
      if (value_r != {CNT_W{1'b0}}) begin
        cnt_nxt_s = value_r - CNT_W'(1);
      end else begin
        timeout_s = 1'b1;
        if (ctrl_r[3]) begin
          cnt_nxt_s    = value_r;
          ctrl_hw_s[0] = 1'b0;
        end else begin
          cnt_nxt_s = reload_r;
        end
      end
    end else begin
      cnt_nxt_s = value_r;
    end
    value_nxt_s = (wr_s && (word_s == OFF_VALUE)) ? apb.PWDATA[CNT_W-1:0] : cnt_nxt_s;
    ctrl_nxt_s  = (wr_s && (word_s == OFF_CTRL))  ? apb.PWDATA[3:0]       : ctrl_hw_s;
  end

  // Interrupt flags: hardware set wins over a same-cycle write-one-to-clear.
  always_comb begin
    capt_set_s    = edge_r & ctrl_r[2];
    w1c_s         = (wr_s && (word_s == OFF_INTSTAT)) ? apb.PWDATA[1:0] : 2'b00;
    intstat_nxt_s = (intstat_r & ~w1c_s) | {capt_set_s, timeout_s};
  end

  // All state, including the CAPIN synchroniser and registered edge pulse.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_r     <= 4'h0;
      value_r    <= {CNT_W{1'b0}};
      reload_r   <= {CNT_W{1'b0}};
      capture_r  <= {CNT_W{1'b0}};
      intstat_r  <= 2'b00;
      sync_r     <= {SYNC_STAGES{1'b0}};
      sync_d_r   <= 1'b0;
      edge_r     <= 1'b0;
      timerint_r <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      value_r    <= value_nxt_s;
      reload_r   <= (wr_s && (word_s == OFF_RELOAD)) ? apb.PWDATA[CNT_W-1:0] : reload_r;
      capture_r  <= capt_set_s ? value_r : capture_r;
      intstat_r  <= intstat_nxt_s;
      sync_r     <= {sync_r[SYNC_STAGES-2:0], CAPIN};
      sync_d_r   <= sync_r[SYNC_STAGES-1];
      edge_r     <= sync_r[SYNC_STAGES-1] & ~sync_d_r;
      timerint_r <= ctrl_r[1] & (|intstat_r);
    end
  end

  assign apb.PRDATA  = rdata_s;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = slverr_s;
  assign TIMERINT    = timerint_r;

  // Byte-lane address bits and write-data bits above the implemented fields are don't-care.
  assign unused_s = ^{apb.PWDATA, apb.PADDR[1:0]};

endmodule
